// File: rtl/lru_lv2_pkg.sv
// Shared definitions for the lv2 tree pseudo-LRU tracker: default geometry,
// node/set count helpers and the tree-state type for the default geometry.
package lru_lv2_pkg;

    localparam int ASSOC_DEF     = 8;
    localparam int ASSOC_WID_DEF = 3;
    localparam int ADDR_WID_DEF  = 16;
    localparam int INDEX_MSB_DEF = 7;
    localparam int INDEX_LSB_DEF = 4;

    // A binary tree over ASSOC leaves has ASSOC-1 internal nodes, numbered 1..ASSOC-1
    function automatic int node_count(input int assoc);
        return assoc - 1;
    endfunction

    function automatic int set_count(input int index_wid);
        return 1 << index_wid;
    endfunction

    typedef logic [ASSOC_DEF-1:1] plru_tree_t;

endpackage

// File: rtl/plru_tree_lv2.sv
// Combinational PLRU tree logic: victim walk over the current tree bits and the
// next tree bits after touching one way (path bits point away from that way).
module plru_tree_lv2
    import lru_lv2_pkg::*;
#(
    parameter int ASSOC     = ASSOC_DEF,
    parameter int ASSOC_WID = ASSOC_WID_DEF
) (
    input  logic [ASSOC-1:1]     tree,
    input  logic [ASSOC_WID-1:0] way,
    output logic [ASSOC_WID-1:0] victim,
    output logic [ASSOC-1:1]     next_tree
);

    logic [ASSOC_WID-1:0] walk_node;
    logic [ASSOC_WID-1:0] upd_node;

    // Descend from the root following the stored bits; the taken directions spell the victim
    always_comb begin
        victim    = '0;
        walk_node = ASSOC_WID'(1);
        for (int lvl = 0; lvl < ASSOC_WID; lvl++) begin
            victim[ASSOC_WID-1-lvl] = tree[walk_node];
            walk_node = (walk_node << 1) | ASSOC_WID'(tree[walk_node]);
        end
    end

    // Follow the accessed way's path and flip each node to point at the other subtree
    always_comb begin
        next_tree = tree;
        upd_node  = ASSOC_WID'(1);
        for (int lvl = 0; lvl < ASSOC_WID; lvl++) begin
            next_tree[upd_node] = ~way[ASSOC_WID-1-lvl];
            upd_node = (upd_node << 1) | ASSOC_WID'(way[ASSOC_WID-1-lvl]);
        end
    end

endmodule

// File: rtl/lru_block_lv2.sv
// Per-set tree pseudo-LRU tracker for the lv2 cache: combinational victim for the
// addressed set, one recency update per completed lv2 transaction.
// Optional macro LRU_LV2_PERF_EN adds update counters lru_upd_cnt / lru_wr_upd_cnt.
module lru_block_lv2
    import lru_lv2_pkg::*;
#(
    parameter int ASSOC     = ASSOC_DEF,
    parameter int ASSOC_WID = ASSOC_WID_DEF,
    parameter int ADDR_WID  = ADDR_WID_DEF,
    parameter int INDEX_MSB = INDEX_MSB_DEF,
    parameter int INDEX_LSB = INDEX_LSB_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_WID-1:0]  addr_bus_lv1_lv2,
    input  logic                 lv2_rd,
    input  logic                 lv2_wr,
    input  logic                 data_in_bus_lv1_lv2,
    input  logic                 lv2_wr_done,
    input  logic [ASSOC_WID-1:0] blk_accessed_main,
    output logic [ASSOC_WID-1:0] lru_replacement_proc
`ifdef LRU_LV2_PERF_EN
    ,
    output logic [31:0]          lru_upd_cnt,
    output logic [31:0]          lru_wr_upd_cnt
`endif
);

    localparam int NODES    = node_count(ASSOC);
    localparam int IDX_WID  = INDEX_MSB - INDEX_LSB + 1;
    localparam int NUM_SETS = set_count(IDX_WID);

    logic [IDX_WID-1:0] set_idx;
    logic [NODES:1]     tree_mem [NUM_SETS];
    logic [NODES:1]     cur_tree;
    logic [NODES:1]     next_tree;
    logic               done;
    logic               done_d;
    logic               upd;
    logic               unused_addr;

    assign set_idx     = addr_bus_lv1_lv2[INDEX_MSB:INDEX_LSB];
    assign unused_addr = ^addr_bus_lv1_lv2;
    assign cur_tree    = tree_mem[set_idx];

    // A completion counts once on its rising edge, and only while a command is active
    assign done = data_in_bus_lv1_lv2 | lv2_wr_done;
    assign upd  = done & ~done_d & (lv2_rd | lv2_wr);

    plru_tree_lv2 #(
        .ASSOC     (ASSOC),
        .ASSOC_WID (ASSOC_WID)
    ) u_tree (
        .tree      (cur_tree),
        .way       (blk_accessed_main),
        .victim    (lru_replacement_proc),
        .next_tree (next_tree)
    );

    // Completion edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d <= 1'b0;
        end else begin
            done_d <= done;
        end
    end

    // Tree state array: only the addressed set is written on an update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_mem[s] <= '0;
            end
        end else if (upd) begin
            tree_mem[set_idx] <= next_tree;
        end
    end

`ifdef LRU_LV2_PERF_EN
    // Free-running update counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_upd_cnt    <= 32'd0;
            lru_wr_upd_cnt <= 32'd0;
        end else begin
            if (upd) begin
                lru_upd_cnt <= lru_upd_cnt + 32'd1;
            end
            if (upd && lv2_wr) begin
                lru_wr_upd_cnt <= lru_wr_upd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lru_block_lv2.sv
// Directed bench for lru_block_lv2 (default 8-way, 16-set geometry): a table of
// transactions with hand-computed victims, plus reset, hold and same-cycle sequences.
module tb_lru_block_lv2;
    import lru_lv2_pkg::*;

    typedef struct {
        int         idx;
        logic       rd;
        logic       wr;
        logic [2:0] way;
        int         chk_idx;
        logic [2:0] exp_victim;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic        din;
    logic        wdone;
    logic [2:0]  way;
    logic [2:0]  victim;
    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vecs [12];
`ifdef LRU_LV2_PERF_EN
    logic [31:0] upd_cnt;
    logic [31:0] wr_upd_cnt;
    int          exp_upd    = 0;
    int          exp_wr_upd = 0;
`endif

    always #5 clk = ~clk;

    lru_block_lv2 dut (
        .clk                  (clk),
        .rst                  (rst),
        .addr_bus_lv1_lv2     (addr),
        .lv2_rd               (rd),
        .lv2_wr               (wr),
        .data_in_bus_lv1_lv2  (din),
        .lv2_wr_done          (wdone),
        .blk_accessed_main    (way),
        .lru_replacement_proc (victim)
`ifdef LRU_LV2_PERF_EN
        ,
        .lru_upd_cnt          (upd_cnt),
        .lru_wr_upd_cnt       (wr_upd_cnt)
`endif
    );

    function automatic logic [15:0] idx_addr(input int i);
        return 16'((i << INDEX_LSB_DEF) | 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_set(input string name, input int i, input logic [2:0] exp);
        addr = idx_addr(i);
        #1;
        check(name, {29'd0, victim}, {29'd0, exp});
    endtask

    task automatic check_perf(input string name);
`ifdef LRU_LV2_PERF_EN
        check({name, "_upd_cnt"}, upd_cnt, 32'(exp_upd));
        check({name, "_wr_upd_cnt"}, wr_upd_cnt, 32'(exp_wr_upd));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    // One completion pulse; writes complete with lv2_wr_done, everything else with read data
    task automatic txn(input int i, input logic rd_i, input logic wr_i, input logic [2:0] way_i);
        @(negedge clk);
        addr = idx_addr(i);
        rd   = rd_i;
        wr   = wr_i;
        way  = way_i;
        if (wr_i) wdone = 1'b1;
        else      din   = 1'b1;
        @(negedge clk);
        din   = 1'b0;
        wdone = 1'b0;
`ifdef LRU_LV2_PERF_EN
        if (rd_i || wr_i) exp_upd++;
        if (wr_i)         exp_wr_upd++;
`endif
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5,  1'b1, 1'b0, 3'd0, 5,  3'd4};
        vecs[1]  = '{6,  1'b0, 1'b0, 3'd3, 6,  3'd0};
        vecs[2]  = '{5,  1'b0, 1'b0, 3'd7, 5,  3'd4};
        vecs[3]  = '{5,  1'b0, 1'b1, 3'd4, 5,  3'd2};
        vecs[4]  = '{5,  1'b1, 1'b0, 3'd2, 5,  3'd6};
        vecs[5]  = '{5,  1'b0, 1'b1, 3'd6, 5,  3'd1};
        vecs[6]  = '{3,  1'b0, 1'b1, 3'd3, 3,  3'd4};
        vecs[7]  = '{3,  1'b1, 1'b0, 3'd4, 3,  3'd0};
        vecs[8]  = '{0,  1'b1, 1'b0, 3'd1, 0,  3'd4};
        vecs[9]  = '{15, 1'b0, 1'b1, 3'd3, 15, 3'd4};
        vecs[10] = '{6,  1'b1, 1'b0, 3'd5, 5,  3'd1};
        vecs[11] = '{0,  1'b0, 1'b0, 3'd6, 0,  3'd4};

        rst = 1'b1; rd = 1'b0; wr = 1'b0; din = 1'b0; wdone = 1'b0; way = 3'd0;
        addr = idx_addr(0);
        repeat (2) @(negedge clk);
        check_set("reset_idx0", 0, 3'd0);
        check_set("reset_idx5", 5, 3'd0);
        check_set("reset_idx15", 15, 3'd0);
        check_perf("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_set("post_reset_idx7", 7, 3'd0);

        for (int v = 0; v < 12; v++) begin
            txn(vecs[v].idx, vecs[v].rd, vecs[v].wr, vecs[v].way);
            check_set($sformatf("vec%0d", v), vecs[v].chk_idx, vecs[v].exp_victim);
        end
        check_perf("table");

        // Long lv2_wr_done hold: a second update with way 4 would move the victim to 2
        @(negedge clk);
        addr = idx_addr(7); wr = 1'b1; way = 3'd0; wdone = 1'b1;
        @(negedge clk);
        way = 3'd4;
        repeat (9) @(negedge clk);
        wdone = 1'b0;
        @(negedge clk);
        wr = 1'b0;
`ifdef LRU_LV2_PERF_EN
        exp_upd++;
        exp_wr_upd++;
`endif
        check_set("hold_single_update", 7, 3'd4);
        check_perf("hold");

        // Pre-update value during the update cycle, post-update value after the edge
        @(negedge clk);
        addr = idx_addr(9); rd = 1'b1; way = 3'd0; din = 1'b1;
        #1;
        check("same_cycle_pre", {29'd0, victim}, 32'd0);
        @(posedge clk);
        #1;
        check("same_cycle_post", {29'd0, victim}, 32'd4);
        @(negedge clk);
        din = 1'b0;
        @(negedge clk);
        rd = 1'b0;
`ifdef LRU_LV2_PERF_EN
        exp_upd++;
`endif

        // Reset in the middle of the third transaction to set 2, completion still high
        txn(2, 1'b1, 1'b0, 3'd0);
        txn(2, 1'b0, 1'b1, 3'd4);
        @(negedge clk);
        addr = idx_addr(2); rd = 1'b1; way = 3'd2; din = 1'b1;
        @(negedge clk);
        check("midrst_before", {29'd0, victim}, 32'd6);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async_clear", {29'd0, victim}, 32'd0);
        check_set("midrst_idx5_cleared", 5, 3'd0);
        addr = idx_addr(2);
`ifdef LRU_LV2_PERF_EN
        exp_upd    = 0;
        exp_wr_upd = 0;
`endif
        @(negedge clk);
        way = 3'd0;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_first_edge_update", {29'd0, victim}, 32'd4);
`ifdef LRU_LV2_PERF_EN
        exp_upd = 1;
`endif
        check_perf("midrst");
        way = 3'd4;
        @(negedge clk);
        check("midrst_no_second_update", {29'd0, victim}, 32'd4);
        din = 1'b0;
        @(negedge clk);
        rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
